// File: rtl/uart_pkg.sv
// Shared types, line constants and helpers for the parametrised UART.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic int calc_div(
    input longint clk_hz,
    input longint baud,
    input longint os
  );
    return int'(clk_hz / (baud * os));
  endfunction

  // Unused upper bits must be zero.
  function automatic logic parity_of(
    input logic [8:0] data,
    input parity_e    mode
  );
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick divider: one-cycle tick every DIV clocks.
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_tick_gen: DIV must be at least 1");
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART with valid/ready on both sides
// and internal loopback.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  input  logic                 rx_in,
  input  logic                 loop_en,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
  localparam parity_e       PMODE   = parity_e'(PARITY);
  localparam bit            HAS_PAR = (PARITY != 0);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_core_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_core_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_core_param: OVERSAMPLE must be even and >= 8");
    end
    if (DIV < 1) begin : g_bad_div
      $error("uart_core_param: clock too slow for BAUD*OVERSAMPLE");
    end
  endgenerate

  // ---------------- transmitter ----------------
  tx_state_e            tx_state, tx_state_d;
  logic [CW-1:0]        tx_cnt, tx_cnt_d;
  logic [3:0]           tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg, tx_shreg_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_line, tx_line_d;
  logic                 tx_tick;
  logic                 tx_accept;
  logic                 tx_bit_end;

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_accept  = tx_valid && tx_ready;
  assign tx_out     = tx_line;
  assign tx_bit_end = tx_tick && (tx_cnt == OS_LAST);

  // Restarted on accept so every bit, including start, is exact.
  uart_tick_gen #(
    .DIV(DIV)
  ) u_tx_tick (
    .clock(clock),
    .reset(reset),
    .clear(tx_accept),
    .tick (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shreg_d = tx_shreg;
    tx_par_d   = tx_par;
    tx_line_d  = tx_line;
    if (tx_state != TX_IDLE && tx_tick) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt + 1'b1;
    end
    unique case (tx_state)
      TX_IDLE: begin
        tx_line_d = LINE_IDLE;
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_shreg_d = tx_data;
          tx_par_d   = parity_of(9'(tx_data), PMODE);
          tx_cnt_d   = '0;
          tx_line_d  = START_BIT;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_shreg[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit == DB_LAST) begin
            tx_bit_d = '0;
            if (HAS_PAR) begin
              tx_state_d = TX_PARITY;
              tx_line_d  = tx_par;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = LINE_IDLE;
            end
          end else begin
            tx_shreg_d = tx_shreg >> 1;
            tx_line_d  = tx_shreg[1];
            tx_bit_d   = tx_bit + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_line_d  = LINE_IDLE;
        end
      end
      TX_STOP: begin
        tx_line_d = LINE_IDLE;
        if (tx_bit_end) begin
          if (tx_bit == SB_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_line  <= LINE_IDLE;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shreg <= tx_shreg_d;
      tx_par   <= tx_par_d;
      tx_line  <= tx_line_d;
    end
  end

  // ---------------- receiver ----------------
  rx_state_e            rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [3:0]           rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg, rx_shreg_d;
  logic                 rx_par, rx_par_d;
  logic                 rx_tick;
  logic                 loop_q;
  logic [2:0]           sync;
  logic                 rx_line;
  logic                 rx_fall;
  logic                 rx_sample;
  logic [CW-1:0]        rx_target;
  logic                 done;
  logic                 done_perr;

  assign rx_line   = sync[1];
  assign rx_fall   = sync[2] && !sync[1];
  assign rx_target = (rx_state == RX_START) ? OS_HALF : OS_LAST;
  assign rx_sample = rx_tick && (rx_cnt == rx_target);
  assign done_perr = HAS_PAR &&
                     (rx_par != parity_of(9'(rx_shreg), PMODE));

  uart_tick_gen #(
    .DIV(DIV)
  ) u_rx_tick (
    .clock(clock),
    .reset(reset),
    .clear(1'b0),
    .tick (rx_tick)
  );

  // Loop select only moves between frames.
  always_ff @(posedge clock) begin
    if (!reset) begin
      loop_q <= 1'b0;
      sync   <= {3{LINE_IDLE}};
    end else begin
      if (rx_state == RX_IDLE) begin
        loop_q <= loop_en;
      end
      sync <= {sync[1:0], loop_q ? tx_line : rx_in};
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shreg_d = rx_shreg;
    rx_par_d   = rx_par;
    done       = 1'b0;
    if (rx_state != RX_IDLE && rx_tick) begin
      rx_cnt_d = rx_sample ? '0 : rx_cnt + 1'b1;
    end
    unique case (rx_state)
      RX_IDLE: begin
        // A held-low line gives no new edge, so breaks cannot re-arm.
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_sample) begin
          if (rx_line) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shreg_d = {rx_line, rx_shreg[DATA_BITS-1:1]};
          if (rx_bit == DB_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_line;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          done       = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shreg <= rx_shreg_d;
      rx_par   <= rx_par_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (done) begin
      rx_data       <= rx_shreg;
      rx_parity_err <= done_perr;
      rx_frame_err  <= !rx_line;
      rx_valid      <= 1'b1;
      rx_overrun    <= rx_valid && !rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Randomised self-checking bench for uart_core_param: three
// configurations (8N1, 7O1, 8N2) sharing one serial input line.
`timescale 1ns/1ps
module tb_uart_core_param;

  localparam int CLK = 1_600_000;
  localparam int BR  = 10_000;
  localparam int OS  = 16;
  localparam int BIT = 160;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx_line = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic       a_tx_valid = 0, a_tx_ready, a_tx_out, a_loop = 0;
  logic       a_rx_valid, a_rx_ready = 0, a_perr, a_ferr, a_ovr;
  logic [7:0] a_tx_data = 0, a_rx_data;
  logic       b_tx_valid = 0, b_tx_ready, b_tx_out, b_loop = 0;
  logic       b_rx_valid, b_rx_ready = 0, b_perr, b_ferr, b_ovr;
  logic [6:0] b_tx_data = 0, b_rx_data;
  logic       c_tx_valid = 0, c_tx_ready, c_tx_out, c_loop = 0;
  logic       c_rx_valid, c_rx_ready = 0, c_perr, c_ferr, c_ovr;
  logic [7:0] c_tx_data = 0, c_rx_data;

  uart_core_param #(
    .CLK_HZ(CLK), .BAUD(BR), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
  ) u_a (
    .clock(clock), .reset(reset),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_data(a_tx_data), .tx_out(a_tx_out),
    .rx_in(rx_line), .loop_en(a_loop),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_data(a_rx_data), .rx_parity_err(a_perr),
    .rx_frame_err(a_ferr), .rx_overrun(a_ovr)
  );

  uart_core_param #(
    .CLK_HZ(CLK), .BAUD(BR), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
  ) u_b (
    .clock(clock), .reset(reset),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .tx_out(b_tx_out),
    .rx_in(rx_line), .loop_en(b_loop),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_data(b_rx_data), .rx_parity_err(b_perr),
    .rx_frame_err(b_ferr), .rx_overrun(b_ovr)
  );

  uart_core_param #(
    .CLK_HZ(CLK), .BAUD(BR), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS)
  ) u_c (
    .clock(clock), .reset(reset),
    .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx_data(c_tx_data), .tx_out(c_tx_out),
    .rx_in(rx_line), .loop_en(c_loop),
    .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_data(c_rx_data), .rx_parity_err(c_perr),
    .rx_frame_err(c_ferr), .rx_overrun(c_ovr)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference frame: line level per bit time, LSB first.
  function automatic logic [12:0] make_frame(
    input logic [8:0] d, input int nb, input int par,
    input int sb, input bit flip, input bit stop_low,
    output int len
  );
    logic [12:0] f;
    int p, ones;
    f = '0;
    p = 1;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      f[p] = d[i];
      ones += int'(d[i]);
      p++;
    end
    if (par != 0) begin
      f[p] = ((par == 1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip;
      p++;
    end
    for (int s = 0; s < sb; s++) begin
      f[p] = !(s == 0 && stop_low);
      p++;
    end
    len = p;
    return f;
  endfunction

  function automatic logic valid_of(input int w);
    case (w)
      0: return a_rx_valid;
      1: return b_rx_valid;
      default: return c_rx_valid;
    endcase
  endfunction

  task automatic wait_rx(input int w, input int bound, output bit ok);
    ok = 0;
    for (int t = 0; t < bound; t++) begin
      if (valid_of(w)) begin
        ok = 1;
        break;
      end
      step(1);
    end
  endtask

  task automatic handshake(input int w);
    case (w)
      0: a_rx_ready = 1;
      1: b_rx_ready = 1;
      default: c_rx_ready = 1;
    endcase
    step(1);
    a_rx_ready = 0;
    b_rx_ready = 0;
    c_rx_ready = 0;
  endtask

  task automatic drive_frame(input logic [12:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      rx_line = f[i];
      step(BIT);
    end
    rx_line = 1;
  endtask

  task automatic test_reset;
    reset = 0;
    step(3);
    total++;
    if ({a_tx_out, a_tx_ready, b_tx_out, b_tx_ready,
         c_tx_out, c_tx_ready} !== 6'b111111) begin
      bad++;
      $display("FAIL reset_tx: got %b want 111111",
               {a_tx_out, a_tx_ready, b_tx_out, b_tx_ready,
                c_tx_out, c_tx_ready});
    end
    total++;
    if ({a_rx_valid, a_perr, a_ferr, a_ovr, a_rx_data,
         b_rx_valid, b_perr, b_ferr, b_ovr, b_rx_data,
         c_rx_valid, c_perr, c_ferr, c_ovr, c_rx_data} !== '0) begin
      bad++;
      $display("FAIL reset_rx: rx outputs not all zero (a=%0h b=%0h c=%0h)",
               a_rx_data, b_rx_data, c_rx_data);
    end
    reset = 1;
    step(2);
  endtask

  task automatic test_loopback;
    logic [7:0]  w;
    logic [12:0] f;
    int len, acc;
    bit ok;
    a_loop = 1;
    step(2);
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 8'hA5 : 8'($urandom);
      f = make_frame(9'(w), 8, 0, 1, 0, 0, len);
      a_tx_data = w;
      a_tx_valid = 1;
      step(1);
      acc = cyc;
      a_tx_valid = 0;
      a_tx_data = ~w;
      total++;
      if (a_tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL lb_busy: tx_ready got %b want 0", a_tx_ready);
      end
      step(BIT / 2);
      for (int i = 0; i < len; i++) begin
        total++;
        if (a_tx_out !== f[i]) begin
          bad++;
          $display("FAIL lb_line w=%h bit%0d: got %b want %b",
                   w, i, a_tx_out, f[i]);
        end
        if (i < len - 1) step(BIT);
      end
      for (int t = 0; t < 400 && !a_tx_ready; t++) step(1);
      total++;
      if (cyc - acc != len * BIT) begin
        bad++;
        $display("FAIL lb_ready_low: got %0d clocks want %0d",
                 cyc - acc, len * BIT);
      end
      wait_rx(0, 400, ok);
      total++;
      if (!ok || a_rx_data !== w || {a_perr, a_ferr, a_ovr} !== 3'b000) begin
        bad++;
        $display("FAIL lb_rx: valid=%b data=%h flags=%b want 1 %h 000",
                 ok, a_rx_data, {a_perr, a_ferr, a_ovr}, w);
      end
      handshake(0);
      total++;
      if (a_rx_valid !== 1'b0) begin
        bad++;
        $display("FAIL lb_hs: rx_valid got %b want 0", a_rx_valid);
      end
    end
    a_loop = 0;
    step(2 * BIT);
  endtask

  task automatic test_parity;
    logic [6:0]  w;
    logic [12:0] f, g;
    int len, acc;
    bit ok, flip;
    handshake(1);
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 7'h55 : 7'($urandom);
      flip = (n == 0) ? 1'b1 : bit'(n % 2);
      f = make_frame(9'(w), 7, 2, 1, 0, 0, len);
      b_tx_data = w;
      b_tx_valid = 1;
      step(1);
      acc = cyc;
      b_tx_valid = 0;
      step(BIT / 2);
      for (int i = 0; i < len; i++) begin
        total++;
        if (b_tx_out !== f[i]) begin
          bad++;
          $display("FAIL par_line w=%h bit%0d: got %b want %b",
                   w, i, b_tx_out, f[i]);
        end
        if (i < len - 1) step(BIT);
      end
      for (int t = 0; t < 400 && !b_tx_ready; t++) step(1);
      total++;
      if (cyc - acc != len * BIT) begin
        bad++;
        $display("FAIL par_ready_low: got %0d want %0d",
                 cyc - acc, len * BIT);
      end
      step(BIT);
      g = make_frame(9'(w), 7, 2, 1, flip, 0, len);
      drive_frame(g, len);
      wait_rx(1, 400, ok);
      total++;
      if (!ok || b_rx_data !== w || b_perr !== flip ||
          b_ferr !== 1'b0 || b_ovr !== 1'b0) begin
        bad++;
        $display("FAIL par_rx: valid=%b data=%h perr=%b ferr=%b want %h %b 0",
                 ok, b_rx_data, b_perr, b_ferr, w, flip);
      end
      handshake(1);
      step(BIT);
    end
  endtask

  task automatic test_false_start;
    logic [7:0]  w;
    logic [12:0] f;
    int len;
    bit ok, seen;
    step(2 * BIT);
    handshake(0);
    rx_line = 0;
    step(60);
    rx_line = 1;
    seen = 0;
    for (int t = 0; t < 400; t++) begin
      if (a_rx_valid) seen = 1;
      step(1);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL false_start: rx_valid got 1 want 0");
    end
    for (int n = 0; n < 3; n++) begin
      w = (n == 0) ? 8'h3C : 8'($urandom);
      f = make_frame(9'(w), 8, 0, 1, 0, 0, len);
      drive_frame(f, len);
      wait_rx(0, 400, ok);
      total++;
      if (!ok || a_rx_data !== w || {a_perr, a_ferr, a_ovr} !== 3'b000) begin
        bad++;
        $display("FAIL fs_rx: valid=%b data=%h flags=%b want 1 %h 000",
                 ok, a_rx_data, {a_perr, a_ferr, a_ovr}, w);
      end
      handshake(0);
      step(BIT);
    end
  endtask

  task automatic test_overrun;
    logic [7:0]  w1, w2;
    logic [12:0] f;
    int len;
    bit ok;
    for (int n = 0; n < 2; n++) begin
      w1 = (n == 0) ? 8'h11 : 8'($urandom);
      w2 = (n == 0) ? 8'h22 : 8'($urandom);
      f = make_frame(9'(w1), 8, 0, 1, 0, 0, len);
      drive_frame(f, len);
      wait_rx(0, 400, ok);
      total++;
      if (!ok || a_rx_data !== w1 || a_ovr !== 1'b0) begin
        bad++;
        $display("FAIL ovr_first: valid=%b data=%h ovr=%b want 1 %h 0",
                 ok, a_rx_data, a_ovr, w1);
      end
      f = make_frame(9'(w2), 8, 0, 1, 0, 0, len);
      drive_frame(f, len);
      total++;
      if (a_rx_valid !== 1'b1 || a_rx_data !== w2 || a_ovr !== 1'b1) begin
        bad++;
        $display("FAIL ovr_second: valid=%b data=%h ovr=%b want 1 %h 1",
                 a_rx_valid, a_rx_data, a_ovr, w2);
      end
      handshake(0);
      total++;
      if (a_rx_valid !== 1'b0 || a_ovr !== 1'b0) begin
        bad++;
        $display("FAIL ovr_clear: valid=%b ovr=%b want 0 0",
                 a_rx_valid, a_ovr);
      end
      step(BIT);
    end
  endtask

  task automatic test_break;
    logic [7:0]  w;
    logic [12:0] f;
    int len;
    bit ok, seen;
    f = make_frame(9'hFF, 8, 0, 1, 0, 1, len);
    drive_frame(f, len);
    wait_rx(0, 400, ok);
    total++;
    if (!ok || a_rx_data !== 8'hFF || a_ferr !== 1'b1 || a_perr !== 1'b0) begin
      bad++;
      $display("FAIL stop_low: valid=%b data=%h ferr=%b want 1 ff 1",
               ok, a_rx_data, a_ferr);
    end
    handshake(0);
    step(BIT);
    rx_line = 0;
    step(2000);
    total++;
    if (a_rx_valid !== 1'b1 || a_rx_data !== 8'h00 ||
        a_ferr !== 1'b1 || a_ovr !== 1'b0) begin
      bad++;
      $display("FAIL break: valid=%b data=%h ferr=%b ovr=%b want 1 00 1 0",
               a_rx_valid, a_rx_data, a_ferr, a_ovr);
    end
    handshake(0);
    seen = 0;
    for (int t = 0; t < 1000; t++) begin
      if (a_rx_valid) seen = 1;
      step(1);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL break_rearm: rx_valid got 1 while line low want 0");
    end
    rx_line = 1;
    step(2 * BIT);
    w = 8'($urandom);
    f = make_frame(9'(w), 8, 0, 1, 0, 0, len);
    drive_frame(f, len);
    wait_rx(0, 400, ok);
    total++;
    if (!ok || a_rx_data !== w || {a_perr, a_ferr} !== 2'b00) begin
      bad++;
      $display("FAIL break_after: valid=%b data=%h ferr=%b want 1 %h 0",
               ok, a_rx_data, a_ferr, w);
    end
    handshake(0);
    step(BIT);
  endtask

  task automatic test_reset_mid;
    logic [7:0]  w;
    logic [12:0] f;
    int len, acc;
    bit ok;
    c_loop = 1;
    step(2);
    c_tx_data = 8'h0F;
    c_tx_valid = 1;
    step(1);
    c_tx_valid = 0;
    step(800);
    total++;
    if (c_tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_busy: tx_ready got %b want 0", c_tx_ready);
    end
    reset = 0;
    step(1);
    total++;
    if (c_tx_out !== 1'b1 || c_tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: tx_out=%b tx_ready=%b want 1 1",
               c_tx_out, c_tx_ready);
    end
    reset = 1;
    step(2 * BIT);
    for (int n = 0; n < 3; n++) begin
      w = (n == 0) ? 8'hF0 : 8'($urandom);
      f = make_frame(9'(w), 8, 0, 2, 0, 0, len);
      c_tx_data = w;
      c_tx_valid = 1;
      step(1);
      acc = cyc;
      c_tx_valid = 0;
      step(BIT / 2);
      for (int i = 0; i < len; i++) begin
        total++;
        if (c_tx_out !== f[i]) begin
          bad++;
          $display("FAIL n2_line w=%h bit%0d: got %b want %b",
                   w, i, c_tx_out, f[i]);
        end
        if (i < len - 1) step(BIT);
      end
      for (int t = 0; t < 400 && !c_tx_ready; t++) step(1);
      total++;
      if (cyc - acc != len * BIT) begin
        bad++;
        $display("FAIL n2_frame_len: got %0d clocks want %0d",
                 cyc - acc, len * BIT);
      end
      wait_rx(2, 400, ok);
      total++;
      if (!ok || c_rx_data !== w || {c_perr, c_ferr, c_ovr} !== 3'b000) begin
        bad++;
        $display("FAIL n2_rx: valid=%b data=%h flags=%b want 1 %h 000",
                 ok, c_rx_data, {c_perr, c_ferr, c_ovr}, w);
      end
      handshake(2);
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_parity;
    test_false_start;
    test_overrun;
    test_break;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART transceiver, the successor to the fixed 8N1 / 9600 baud tx+rx pair.
- Configurable baud, data width, parity mode, stop bits and oversampling.
- Valid/ready handshakes on both the tx and rx sides; errored frames are reported, not silently dropped.
- Internal loopback mode for self-test.
- Sits between a bus-side register block and the chip pads.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line bit rate
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, rx samples per bit; must be even and >= 8

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
tx_valid  in  1  tx_data is valid
tx_ready  out  1  transmitter can accept a word
tx_data  in  DATA_BITS  word to send, LSB first
tx_out  out  1  serial line output; idles high
rx_in  in  1  serial line input; asynchronous to clock
loop_en  in  1  1 = receiver takes internal tx_out instead of rx_in
rx_valid  out  1  received word available
rx_ready  in  1  consumer accepts rx_data
rx_data  out  DATA_BITS  received word
rx_parity_err  out  1  parity mismatch on the current rx_data
rx_frame_err  out  1  first stop bit sampled low
rx_overrun  out  1  a frame completed while rx_valid was still high

Behaviour:
- Reset (reset = 0 at a clock edge):
  - tx_out = 1, tx_ready = 1.
  - rx_valid, rx_parity_err, rx_frame_err, rx_overrun = 0; rx_data = 0.
  - Both FSMs go to IDLE and the tick divider clears.
  - Reset asserted mid-frame aborts the frame; the line is high on the following cycle.
- Tick generator:
  - DIV = CLK_HZ / (BAUD * OVERSAMPLE), integer-truncated.
  - Emits a one-cycle tick every DIV clocks; free-running once out of reset.
  - DIV < 1 is an elaboration error.
- TX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - A word is accepted on a clock where tx_valid && tx_ready; the word is latched and tx_ready goes low the next cycle.
  - Each bit lasts exactly OVERSAMPLE ticks.
  - STOP lasts STOP_BITS bit times.
  - tx_ready returns high in the cycle after the final stop tick.
  - Parity bit = XOR of data for even, XNOR for odd.
  - tx_data changes while busy have no effect.
- RX input conditioning:
  - 2-flop synchroniser on the selected input (rx_in or internal tx_out).
  - loop_en is sampled only in IDLE; a change mid-frame takes effect on the next frame.
- RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a high->low transition on the synchronised line enters START.
  - START: the line is resampled after OVERSAMPLE/2 ticks. If high, it is a false start: return to IDLE with no output.
  - Each later bit is sampled every OVERSAMPLE ticks, at mid-bit.
  - Only the first stop bit is checked. The FSM returns to IDLE at the first stop-bit sample, so the receiver can accept 1-stop-bit frames even when STOP_BITS = 2.
- RX completion (at the stop-bit sample):
  - rx_data and both error flags load; rx_valid goes high the next cycle.
  - Errored frames still raise rx_valid.
  - rx_valid, rx_data and the error flags hold until a cycle with rx_valid && rx_ready, after which rx_valid = 0.
  - If a new frame completes while rx_valid = 1: rx_data and the error flags are overwritten, rx_overrun = 1 (sticky), and rx_valid stays 1.
  - rx_overrun clears on the handshake cycle.
  - If a completion and a handshake occur in the same cycle: the new word is loaded, rx_valid stays 1, and no overrun is flagged.
- Break condition (line held low for a whole frame): reported as rx_frame_err = 1 with rx_data = 0. The receiver then waits for the line to go high before it re-arms.
- DATA_BITS = 9: the word is carried on the full port width; no special handling.

Decomposition:
- Package uart_pkg:
  - parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
  - tx_state_e and rx_state_e
  - function calc_div(clk_hz, baud, os)
  - constants LINE_IDLE = 1'b1 and START_BIT = 1'b0
- One natural sub-module: uart_tick_gen (parametrised divider that outputs the tick).
- TX and RX FSMs stay in uart_core_param.

Test Plan:
All scenarios use CLK_HZ = 1_600_000, BAUD = 10_000, OVERSAMPLE = 16, giving DIV = 10 and 160 clocks per bit.
1. 8N1, loop_en = 1, send 0xA5 -> tx_out carries 0, 1,0,1,0,0,1,0,1, 1 at 160 clocks/bit; tx_ready is low for 1600 clocks; rx_valid rises with rx_data = 0xA5 and no error flags.
2. PARITY = 2, DATA_BITS = 7, send 0x55 -> parity bit = 1 on the line; drive rx_in with a corrupted parity bit -> rx_parity_err = 1 and rx_data = 0x55.
3. Drive rx_in low for 60 clocks, then high -> false start; rx_valid never asserts and the next valid frame 0x3C is received correctly.
4. Hold rx_ready = 0 and receive 0x11 then 0x22 -> rx_data = 0x22 and rx_overrun = 1; pulse rx_ready -> rx_valid = 0 and rx_overrun = 0 on the next cycle.
5. Stop bit driven low on frame 0xFF -> rx_frame_err = 1; hold rx_in low for 2000 clocks -> a single frame_err frame with rx_data = 0, and no further rx_valid until the line returns high.
6. Assert reset for 1 cycle halfway through transmitting 0x0F -> the next cycle shows tx_out = 1 and tx_ready = 1; a fresh 0xF0 then transmits cleanly with STOP_BITS = 2, giving a 1760-clock frame.
